// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel among NREQ requesters.
// A grant lasts one packet or MAXLEN bytes, followed by an optional idle gap.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DLEN    = 8,
    parameter int MAXLEN  = 16,
    parameter int GAP_CYC = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*DLEN-1:0] i_req_data,
    input  logic [NREQ-1:0]      i_req_last,
    output logic                 o_wvalid,
    input  logic                 i_wready,
    output logic [DLEN-1:0]      o_wdata,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);

    localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW       = $clog2(MAXLEN + 1);
    localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   g_idx;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic [CW-1:0]   byte_ct;
    logic [GW-1:0]   gap_ct;
    logic            in_xfer;
    logic            hs;
    logic            release_now;

    // Search starts just after the previous owner, so it ends up lowest priority.
    always_comb begin
        logic [PW-1:0] idx;
        pick_idx   = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(rr_ptr) + i) % NREQ);
            if (!pick_found && i_req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    assign in_xfer     = (state == XFER);
    assign o_wvalid    = in_xfer && i_req_valid[g_idx];
    assign o_wdata     = in_xfer ? i_req_data[g_idx*DLEN +: DLEN] : '0;
    assign o_req_ready = in_xfer ? (NREQ'(i_wready) << g_idx) : '0;
    assign o_busy      = (state == XFER) || (state == GAP);
    assign hs          = o_wvalid && i_wready;
    assign release_now = hs && (i_req_last[g_idx] ||
                                byte_ct == CW'(MAXLEN - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            o_grant <= '0;
            rr_ptr  <= PW'(NREQ - 1);
            g_idx   <= '0;
            byte_ct <= '0;
            gap_ct  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        g_idx   <= pick_idx;
                        o_grant <= NREQ'(1) << pick_idx;
                        byte_ct <= '0;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (release_now) begin
                        rr_ptr  <= g_idx;
                        byte_ct <= '0;
                        o_grant <= '0;
                        gap_ct  <= '0;
                        state   <= (GAP_CYC > 0) ? GAP : IDLE;
                    end else if (hs) begin
                        byte_ct <= byte_ct + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_ct == GW'(GAP_LAST)) begin
                        state <= IDLE;
                    end else begin
                        gap_ct <= gap_ct + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_grant <= '0;
`ifndef SYNTHESIS
                    $error("uart_tx_arbiter: illegal state %0d", state);
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NREQ=4, MAXLEN=4, GAP_CYC=3).
// Directed packets feed per-requester queues; a monitor checks every byte.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DLEN    = 8;
    localparam int MAXLEN  = 4;
    localparam int GAP_CYC = 3;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DLEN-1:0] req_data = '0;
    logic [NREQ-1:0]      req_last = '0;
    logic                 wvalid;
    logic                 wready = 1'b0;
    logic [DLEN-1:0]      wdata;
    logic [NREQ-1:0]      grant;
    logic                 busy;

    typedef struct packed {
        logic [1:0] req;
        logic [7:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [8:0]  src[NREQ][$];
    logic [3:0]  rdy_s = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    uart_tx_arbiter #(
        .NREQ(NREQ), .DLEN(DLEN), .MAXLEN(MAXLEN), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_data(req_data),
        .i_req_last(req_last),
        .o_wvalid(wvalid),
        .i_wready(wready),
        .o_wdata(wdata),
        .o_grant(grant),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Requester models: present queue head, pop on the accepting edge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (rdy_s[k] && src[k].size() > 0) void'(src[k].pop_front());
        end
        for (int k = 0; k < NREQ; k++) begin
            if (src[k].size() > 0) begin
                req_valid[k]           = 1'b1;
                req_data[k*DLEN +: DLEN] = src[k][0][7:0];
                req_last[k]            = src[k][0][8];
            end else begin
                req_valid[k]           = 1'b0;
                req_data[k*DLEN +: DLEN] = '0;
                req_last[k]            = 1'b0;
            end
        end
    end

    // Monitor: every byte handed to uart_tx must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        rdy_s = req_ready;
        if (rstn && wvalid && wready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL byte_unexpected: grant=%b data=%h required none",
                         grant, wdata);
            end else begin
                e = sb.pop_front();
                if (grant !== (4'b0001 << e.req) || wdata !== e.data ||
                    req_ready !== grant) begin
                    n_bad++;
                    $display("FAIL byte: grant=%b data=%h ready=%b required req%0d data=%h",
                             grant, wdata, req_ready, e.req, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic send(input int r, input logic [7:0] d0, input int n);
        for (int i = 0; i < n; i++) begin
            src[r].push_back({(i == n - 1), 8'(d0 + i)});
        end
    endtask

    task automatic expect_run(input int r, input logic [7:0] d0, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.req  = 2'(r);
            e.data = 8'(d0 + i);
            sb.push_back(e);
        end
    endtask

    task automatic wait_sb(input int n, input string nm);
        int t = 0;
        while (sb.size() > n && t < 200) begin
            tick();
            t++;
        end
        chk(nm, 32'(sb.size() <= n), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while ((sb.size() > 0 || busy || |req_valid) && t < 300) begin
            tick();
            t++;
        end
        chk(nm, 32'(sb.size() == 0 && !busy && req_valid == '0), 32'd1);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_grant"}, 32'(grant), 32'd0);
        chk({nm, "_wvalid"}, 32'(wvalid), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_ready"}, 32'(req_ready), 32'd0);
        chk({nm, "_wdata"}, 32'(wdata), 32'd0);
    endtask

    initial begin
        int t;
        int gaps;
        int idles;

        wready = 1'b1;
        rstn   = 1'b0;
        tick();
        tick();
        chk_quiet("reset");
        rstn = 1'b1;
        tick();
        chk_quiet("after_reset");

        // Single 3-byte packet from req0; 1-clk arbitration latency.
        send(0, 8'hA1, 3);
        expect_run(0, 8'hA1, 3);
        t = 0;
        while (!req_valid[0] && t < 10) begin
            tick();
            t++;
        end
        chk("t1_valid", 32'(req_valid[0]), 32'd1);
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_wvalid", 32'(wvalid), 32'd1);
        chk("t1_wdata", 32'(wdata), 32'hA1);
        repeat (3) tick();
        chk("t1_rel_grant", 32'(grant), 32'd0);
        chk("t1_rel_wvalid", 32'(wvalid), 32'd0);
        chk("t1_rel_busy", 32'(busy), 32'd1);
        wait_idle("t1_done");

        // Fresh reset, then all four requesters: order 0,1,2,3,0.
        rstn = 1'b0;
        tick();
        tick();
        chk_quiet("t2_reset");
        rstn = 1'b1;
        send(0, 8'h10, 2);
        send(0, 8'h50, 2);
        send(1, 8'h20, 2);
        send(2, 8'h30, 2);
        send(3, 8'h40, 2);
        expect_run(0, 8'h10, 2);
        expect_run(1, 8'h20, 2);
        expect_run(2, 8'h30, 2);
        expect_run(3, 8'h40, 2);
        expect_run(0, 8'h50, 2);
        wait_idle("t2_done");

        // 10-byte packet truncated at MAXLEN, resumed after req3.
        send(2, 8'h60, 10);
        send(3, 8'h70, 3);
        expect_run(2, 8'h60, 4);
        expect_run(3, 8'h70, 3);
        expect_run(2, 8'h64, 4);
        expect_run(2, 8'h68, 2);
        wait_idle("t3_done");

        // Stall mid-packet; req0 waiting exposes any premature release.
        send(1, 8'h80, 6);
        expect_run(1, 8'h80, 4);
        expect_run(0, 8'h90, 1);
        expect_run(1, 8'h84, 2);
        wait_sb(5, "t4_reach");
        wready = 1'b0;
        send(0, 8'h90, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_wvalid", 32'(wvalid), 32'd1);
            chk("t4_wdata", 32'(wdata), 32'h82);
            chk("t4_ready", 32'(req_ready), 32'd0);
            chk("t4_grant", 32'(grant), 32'h2);
        end
        wready = 1'b1;
        wait_idle("t4_done");

        // Back-to-back packets from one requester: 3 GAP + 1 IDLE clocks.
        send(3, 8'hB0, 2);
        send(3, 8'hC0, 1);
        expect_run(3, 8'hB0, 2);
        expect_run(3, 8'hC0, 1);
        wait_sb(1, "t5_reach");
        gaps  = 0;
        idles = 0;
        t     = 0;
        while (!wvalid && t < 20) begin
            gaps++;
            if (!busy) idles++;
            tick();
            t++;
        end
        chk("t5_gap_clks", 32'(gaps), 32'd4);
        chk("t5_idle_clks", 32'(idles), 32'd1);
        wait_idle("t5_done");

        // Reset with byte 2 of 4 pending; req0 must win after release.
        send(1, 8'hD0, 4);
        expect_run(1, 8'hD0, 1);
        wait_sb(0, "t6_reach");
        wready = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        chk_quiet("t6_reset");
        send(0, 8'hE0, 1);
        tick();
        tick();
        expect_run(0, 8'hE0, 1);
        expect_run(1, 8'hD1, 3);
        rstn   = 1'b1;
        wready = 1'b1;
        wait_idle("t6_done");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
